// File: rtl/panda_risc_v_pkg.sv
// Shared constants and helpers for the panda_risc_v instruction-fetch path.
package panda_risc_v_pkg;

  localparam int IF_RES_DATA_W = 128;
  localparam int IF_RES_MSG_W  = 4;

  // Bit positions inside the 4-bit fetch message.
  localparam int PRDT_JUMP   = 3;
  localparam int ILLEGAL     = 2;
  localparam int ERR_MSB     = 1;
  localparam int ERR_LSB     = 0;

  // Field boundaries inside the 128-bit fetch data word.
  localparam int PC_MSB      = 127;
  localparam int PC_LSB      = 96;

  typedef enum logic [1:0] {
    IMEM_OK      = 2'b00,
    IMEM_PMP_ERR = 2'b01,
    IMEM_BUS_ERR = 2'b10,
    IMEM_TIMEOUT = 2'b11
  } imem_err_e;

  function automatic logic [31:0] if_res_pc(input logic [IF_RES_DATA_W-1:0] data);
    return data[PC_MSB:PC_LSB];
  endfunction

endpackage

// File: rtl/panda_risc_v_fifo_regs.sv
// Generic first-word-fall-through register FIFO with synchronous clear.
module panda_risc_v_fifo_regs
  import panda_risc_v_pkg::*;
#(
  parameter int depth = 4,
  parameter int width = 136,
  localparam int ptr_w = $clog2(depth),
  localparam int cnt_w = ptr_w + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wen,
  input  logic [width-1:0] wdata,
  input  logic             ren,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [cnt_w-1:0] cnt
);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wptr;
  logic [ptr_w-1:0] rptr;
  logic             push;
  logic             pop;

  assign full  = (cnt == cnt_w'(depth));
  assign empty = (cnt == '0);
  assign push  = wen & ~full & ~clr;
  assign pop   = ren & ~empty & ~clr;
  assign rdata = mem[rptr];

  // NOTE: storage has no reset; every entry is written before valid ever
  // points at it, so resetting it would only cost flops and fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + ptr_w'(1);
      if (pop)  rptr <= rptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + cnt_w'(1);
        2'b01:   cnt <= cnt - cnt_w'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/panda_risc_v_if_res_buf.sv
// Fetch-result buffer: stamps wrapping instruction IDs and presents entries FWFT.
// Optional zero-latency empty-buffer bypass: define PANDA_RISC_V_IF_RES_BUF_BYPASS_EN.
module panda_risc_v_if_res_buf
  import panda_risc_v_pkg::*;
#(
  parameter int fifo_depth       = 4,
  parameter int inst_id_width    = 4,
  parameter int simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     sys_resetn,
  input  logic                     sys_reset_req,
  input  logic                     flush_req,
  input  logic [127:0]             s_if_data,
  input  logic [3:0]               s_if_msg,
  input  logic                     s_if_valid,
  output logic                     s_if_ready,
  output logic [127:0]             m_if_res_data,
  output logic [3:0]               m_if_res_msg,
  output logic [inst_id_width-1:0] m_if_res_id,
  output logic                     m_if_res_valid,
  input  logic                     m_if_res_ready,
  output logic [4:0]               buf_cnt
);

  localparam int entry_w = IF_RES_DATA_W + IF_RES_MSG_W + inst_id_width;
  localparam int cnt_w   = $clog2(fifo_depth) + 1;

  // Register updates are zero-delay in this implementation.
  if (simulation_delay < 0) begin : g_bad_sim_delay
  end

  logic                     clr;
  logic                     push_acc;
  logic [inst_id_width-1:0] id_cnt;
  logic                     fifo_wen;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [cnt_w-1:0]         fifo_cnt;
  logic [entry_w-1:0]       head;
  logic [IF_RES_DATA_W-1:0] head_data;
  logic [IF_RES_MSG_W-1:0]  head_msg;
  logic [inst_id_width-1:0] head_id;

  assign clr        = flush_req | sys_reset_req;
  assign s_if_ready = ~fifo_full;
  assign push_acc   = s_if_valid & s_if_ready & ~clr;
  assign buf_cnt    = 5'(fifo_cnt);
  assign {head_data, head_msg, head_id} = head;

  // IDs survive flushes so in-flight dependency tracking never sees a reuse.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      id_cnt <= '0;
    end else if (sys_reset_req) begin
      id_cnt <= '0;
    end else if (push_acc) begin
      id_cnt <= id_cnt + inst_id_width'(1);
    end
  end

`ifdef PANDA_RISC_V_IF_RES_BUF_BYPASS_EN
  logic bypass;

  assign bypass         = fifo_empty & s_if_valid & ~clr;
  // A bypassed beat taken by decode this cycle never needs a storage slot.
  assign fifo_wen       = s_if_valid & ~(bypass & m_if_res_ready);
  assign m_if_res_valid = ~fifo_empty | bypass;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    m_if_res_data = head_data;
    m_if_res_msg  = head_msg;
    m_if_res_id   = fifo_empty ? id_cnt : head_id;
    if (bypass) begin
      m_if_res_data = s_if_data;
      m_if_res_msg  = s_if_msg;
      m_if_res_id   = id_cnt;
    end
  end
`else
  assign fifo_wen       = s_if_valid;
  assign m_if_res_valid = ~fifo_empty;
  assign m_if_res_data  = head_data;
  assign m_if_res_msg   = head_msg;
  // While empty, show the ID the next entry will receive instead of stale storage.
  assign m_if_res_id    = fifo_empty ? id_cnt : head_id;
`endif

  panda_risc_v_fifo_regs #(
    .depth (fifo_depth),
    .width (entry_w)
  ) u_fifo (
    .clk   (clk),
    .rst_n (sys_resetn),
    .clr   (clr),
    .wen   (fifo_wen),
    .wdata ({s_if_data, s_if_msg, id_cnt}),
    .ren   (m_if_res_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_panda_risc_v_if_res_buf.sv
// Self-checking bench for panda_risc_v_if_res_buf against a queue-based model.
module tb_panda_risc_v_if_res_buf;
  import panda_risc_v_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  typedef struct packed {
    logic [127:0]    data;
    logic [3:0]      msg;
    logic [ID_W-1:0] id;
  } ent_t;

  logic            clk = 1'b0;
  logic            sys_resetn;
  logic            sys_reset_req;
  logic            flush_req;
  logic [127:0]    s_if_data;
  logic [3:0]      s_if_msg;
  logic            s_if_valid;
  logic            s_if_ready;
  logic [127:0]    m_if_res_data;
  logic [3:0]      m_if_res_msg;
  logic [ID_W-1:0] m_if_res_id;
  logic            m_if_res_valid;
  logic            m_if_res_ready;
  logic [4:0]      buf_cnt;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   model_id = 0;

  always #5 clk = ~clk;

  panda_risc_v_if_res_buf #(
    .fifo_depth       (DEPTH),
    .inst_id_width    (ID_W),
    .simulation_delay (1)
  ) dut (
    .clk            (clk),
    .sys_resetn     (sys_resetn),
    .sys_reset_req  (sys_reset_req),
    .flush_req      (flush_req),
    .s_if_data      (s_if_data),
    .s_if_msg       (s_if_msg),
    .s_if_valid     (s_if_valid),
    .s_if_ready     (s_if_ready),
    .m_if_res_data  (m_if_res_data),
    .m_if_res_msg   (m_if_res_msg),
    .m_if_res_id    (m_if_res_id),
    .m_if_res_valid (m_if_res_valid),
    .m_if_res_ready (m_if_res_ready),
    .buf_cnt        (buf_cnt)
  );

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] pc);
    return {pc, $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle();
    s_if_valid     = 1'b0;
    m_if_res_ready = 1'b0;
    flush_req      = 1'b0;
    sys_reset_req  = 1'b0;
    #1;
  endtask

  // One clock: apply inputs, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input logic v, input logic [127:0] d, input logic [3:0] m,
                       input logic rdy, input logic fl, input logic sr);
    logic clr, push, pop, bp, exp_valid;
    ent_t head_e;
    s_if_valid     = v;
    s_if_data      = d;
    s_if_msg       = m;
    m_if_res_ready = rdy;
    flush_req      = fl;
    sys_reset_req  = sr;
    @(negedge clk);
    clr = fl | sr;
    bp  = 1'b0;
`ifdef PANDA_RISC_V_IF_RES_BUF_BYPASS_EN
    bp = (q.size() == 0) && v && !clr;
`endif
    exp_valid = (q.size() != 0) || bp;
    check("s_if_ready", 136'(s_if_ready), 136'(q.size() < DEPTH));
    check("m_valid", 136'(m_if_res_valid), 136'(exp_valid));
    check("buf_cnt", 136'(buf_cnt), 136'(q.size()));
    if (exp_valid) begin
      head_e = bp ? ent_t'{data: d, msg: m, id: ID_W'(model_id)} : q[0];
      check("head_data", 136'(m_if_res_data), 136'(head_e.data));
      check("head_msg", 136'(m_if_res_msg), 136'(head_e.msg));
      check("head_id", 136'(m_if_res_id), 136'(head_e.id));
    end
    push = v && (q.size() < DEPTH) && !clr;
    pop  = (q.size() != 0) && rdy && !clr;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!(bp && rdy)) q.push_back(ent_t'{data: d, msg: m, id: ID_W'(model_id)});
      model_id = (model_id + 1) % (1 << ID_W);
    end
    if (sr)  model_id = 0;
    if (clr) q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_resetn     = 1'b0;
    sys_reset_req  = 1'b0;
    flush_req      = 1'b0;
    s_if_valid     = 1'b0;
    s_if_data      = '0;
    s_if_msg       = '0;
    m_if_res_ready = 1'b0;
    #12;
    check("rst_s_ready", 136'(s_if_ready), 136'(1));
    check("rst_m_valid", 136'(m_if_res_valid), 136'(0));
    check("rst_buf_cnt", 136'(buf_cnt), 136'(0));
    check("rst_m_id", 136'(m_if_res_id), 136'(0));
    @(negedge clk);
    sys_resetn = 1'b1;
    @(posedge clk);
    #1;

    // Three entries held, then drained in order.
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'(i * 4)), 4'($urandom()), 1'b0, 1'b0, 1'b0);
    idle();
    check("t1_cnt", 136'(buf_cnt), 136'(3));
    check("t1_head_pc", 136'(if_res_pc(m_if_res_data)), 136'(0));
    check("t1_head_id", 136'(m_if_res_id), 136'(0));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Full buffer refuses a push even while popping.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(32'($urandom())), 4'($urandom()), 1'b0, 1'b0, 1'b0);
    idle();
    check("t2_full_ready", 136'(s_if_ready), 136'(0));
    check("t2_full_cnt", 136'(buf_cnt), 136'(DEPTH));
    cycle(1'b1, mk(32'h1234), 4'h5, 1'b1, 1'b0, 1'b0);
    idle();
    check("t2_cnt_after", 136'(buf_cnt), 136'(DEPTH - 1));
    drain();

    // ID wrap across 18 back-to-back pushes.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) cycle(1'b1, mk(32'(i * 4)), 4'($urandom()), 1'b1, 1'b0, 1'b0);
`ifndef PANDA_RISC_V_IF_RES_BUF_BYPASS_EN
    idle();
    check("t3_wrap_id", 136'(m_if_res_id), 136'(1));
`endif
    drain();

    // Flush keeps IDs running; software reset restarts them.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'($urandom())), 4'($urandom()), 1'b1, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 2; i++) cycle(1'b1, mk(32'($urandom())), 4'($urandom()), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(32'hdead), 4'h1, 1'b1, 1'b1, 1'b0);
    idle();
    check("t4_flush_cnt", 136'(buf_cnt), 136'(0));
    check("t4_flush_valid", 136'(m_if_res_valid), 136'(0));
    cycle(1'b1, mk(32'h40), 4'h2, 1'b0, 1'b0, 1'b0);
    idle();
    check("t4_id_after_flush", 136'(m_if_res_id), 136'(7));
    cycle(1'b1, mk(32'h44), 4'h3, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, mk(32'h48), 4'h4, 1'b0, 1'b0, 1'b0);
    idle();
    check("t4_id_after_swrst", 136'(m_if_res_id), 136'(0));
    drain();

    // Steady push+pop at occupancy 2.
    for (int i = 0; i < 2; i++) cycle(1'b1, mk(32'($urandom())), 4'($urandom()), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(32'($urandom())), 4'($urandom()), 1'b1, 1'b0, 1'b0);
    idle();
    check("t5_cnt_steady", 136'(buf_cnt), 136'(2));
    drain();

`ifdef PANDA_RISC_V_IF_RES_BUF_BYPASS_EN
    // Empty buffer forwards and consumes in the same cycle.
    cycle(1'b1, mk(32'h80), 4'h8, 1'b1, 1'b0, 1'b0);
    idle();
    check("t6_bypass_cnt", 136'(buf_cnt), 136'(0));
    check("t6_bypass_next_id", 136'(m_if_res_id), 136'(model_id));
`endif

    // Randomized traffic with occasional flushes and software resets.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), mk($urandom()), 4'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 96) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
